// File: rtl/ysyx_23060332_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_fetch_ctrl_if
//
// Purpose: groups the fetch controller's two handshakes into one bundle. The
//          first is the instruction-memory request/response channel. The
//          second is the channel that hands the fetched instruction to the IDU.
//
// Signals:
//   imem_req_valid / imem_req_ready / imem_req_addr  : fetch request channel
//   imem_rsp_valid / imem_rsp_ready / imem_rsp_data  : fetch response channel
//   inst_valid / inst_ready / inst / inst_pc         : instruction to the IDU
//
// Modports:
//   master : the fetch controller (drives requests and instructions)
//   slave  : the memory + IDU side (drives readies and response data)
// ----------------------------------------------------------------------------
interface ysyx_23060332_fetch_ctrl_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_ready;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, imem_rsp_ready,
      output inst_valid, inst, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, imem_rsp_ready,
      input  inst_valid, inst, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
   );
endinterface

// File: rtl/ysyx_23060332_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_fetch_ctrl
//
// Purpose: instruction-fetch controller. It owns the fetch PC and runs one
//          fetch at a time: request -> response -> hand the instruction to the
//          IDU. EXU redirects are applied immediately when nothing is in
//          flight. Otherwise they are remembered, the in-flight fetch is
//          completed on the bus, its response is thrown away, and the
//          remembered target is fetched next.
//
// Parameters:
//   RESET_PC    : fetch address after reset (default 32'h8000_0000)
//
// Ports:
//   clk         : clock
//   rst         : synchronous, active-high reset
//   jump_en     : one-cycle redirect pulse from the EXU
//   jump_addr   : redirect target, sampled when jump_en is 1
//   bus         : fetch_ctrl_if master (imem request/response, IDU handshake)
//   pc          : current fetch PC (registered)
//   fetch_fault : misaligned redirect target taken
//
// Build option:
//   YSYX_23060332_MISALIGN_CHK_EN : when defined, a redirect to an address
//     with nonzero low bits enters FAULT and raises fetch_fault. FAULT is
//     left only by an aligned redirect or by reset. When the macro is
//     undefined, redirect targets are forced to word alignment,
//     fetch_fault is tied 0 and FAULT is unreachable.
// ----------------------------------------------------------------------------
module ysyx_23060332_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              jump_en,
   input  logic [31:0]                       jump_addr,
   ysyx_23060332_fetch_ctrl_if.master        bus,
   output logic [31:0]                       pc,
   output logic                              fetch_fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        rp_q, rp_d;         // redirect target waiting in rp_addr_q
   logic        drop_q, drop_d;     // the outstanding fetch is stale
   logic [31:0] rp_addr_q;

   logic        apply;              // load pc from redir_addr this cycle
   logic [31:0] redir_addr;
   logic [31:0] redir_pc;
   logic        redir_bad;

   // A fresh jump always beats a remembered one. The remembered target is
   // applied only when a stale response is consumed in WAIT and no new jump
   // arrives in that same cycle.
   assign redir_addr = (state_q == S_WAIT && bus.imem_rsp_valid && !jump_en)
                       ? rp_addr_q : jump_addr;

`ifdef YSYX_23060332_MISALIGN_CHK_EN
   assign redir_pc    = redir_addr;
   assign redir_bad   = (redir_addr[1:0] != 2'b00);
   assign fetch_fault = (state_q == S_FAULT);
`else
   assign redir_pc    = redir_addr & 32'hFFFF_FFFC;
   assign redir_bad   = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   always_comb begin
      // NOTE: every next-state value takes its hold value first, so no path
      // through the case statement leaves a signal unassigned (no latches).
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      rp_d         = rp_q;
      drop_d       = drop_q;
      apply        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (jump_en) apply = 1'b1;
            else         state_d = S_REQ;
         end
         S_REQ: begin
            // pc is frozen here, so the request address stays stable until
            // it is accepted. A jump is only remembered.
            if (jump_en) begin
               rp_d   = 1'b1;
               drop_d = 1'b1;
            end
            if (bus.imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.imem_rsp_valid) begin
               if (jump_en || rp_q || drop_q) begin
                  apply = 1'b1;     // stale response: discard it and retarget
               end else begin
                  inst_d       = bus.imem_rsp_data;
                  inst_pc_d    = pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = S_HOLD;
               end
            end else if (jump_en) begin
               rp_d   = 1'b1;
               drop_d = 1'b1;
            end
         end
         S_HOLD: begin
            // A jump wins over inst_ready. The IDU handshake still completes
            // in that cycle because inst_valid was 1.
            if (jump_en) begin
               apply = 1'b1;
            end else if (bus.inst_ready) begin
               inst_valid_d = 1'b0;
               pc_d         = pc_q + 32'd4;
               state_d      = S_REQ;
            end
         end
         S_FAULT: begin
            if (jump_en) apply = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (apply) begin
         pc_d         = redir_pc;
         inst_valid_d = 1'b0;
         rp_d         = 1'b0;
         drop_d       = 1'b0;
         state_d      = redir_bad ? S_FAULT : S_REQ;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         rp_q         <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         rp_q         <= rp_d;
         drop_q       <= drop_d;
      end
   end

   // NOTE: rp_addr_q is read only while rp_q is set, and rp_q is reset, so
   // this data register has no reset.
   always_ff @(posedge clk) begin
      if (jump_en && (state_q == S_REQ || state_q == S_WAIT)) rp_addr_q <= jump_addr;
   end

   assign bus.imem_req_valid = (state_q == S_REQ);
   assign bus.imem_req_addr  = pc_q;
   assign bus.imem_rsp_ready = (state_q == S_WAIT);
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign pc                 = pc_q;

endmodule

// File: tb/tb_ysyx_23060332_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060332_fetch_ctrl
//
// Purpose: self-checking bench for the fetch controller. The bench plays two
//          roles: the instruction memory (random accept delay and response
//          latency) and the IDU (random inst_ready). It also drives EXU
//          redirects.
//
// The reference model works at the level of program order. It tracks the
// next address to fetch, whether a redirect target is waiting, and whether an
// instruction is being offered. It updates only on the bus handshakes the
// bench itself takes part in. Expected request addresses and expected
// (inst_pc, inst) pairs go into queues. A separate monitor pops and compares
// them whenever a handshake happens.
// ----------------------------------------------------------------------------
module tb_ysyx_23060332_fetch_ctrl;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic [31:0] pc;
   logic        fetch_fault;

   ysyx_23060332_fetch_ctrl_if bus();

   ysyx_23060332_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .bus         (bus),
      .pc          (pc),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // ---------------- stimulus knobs ----------------
   int          req_rdy_pct, lat_lo, lat_hi, inst_rdy_pct, jump_pct;
   bit          force_jump;
   logic [31:0] force_addr;

   // ---------------- memory model state ----------------
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } inst_t;

   logic [31:0] exp_req_q[$];
   inst_t       exp_inst_q[$];
   logic [31:0] m_fetch_addr;   // address the current fetch targets
   logic [31:0] m_pend_addr;    // remembered redirect target
   bit          m_pend;         // a redirect is waiting for the stale response
   bit          m_held;         // an instruction is being offered to the IDU
   bit          m_fault;        // stopped on a misaligned target

   int          cyc, since_rst, n_delivered;
   bit          last_req_hs;
   logic [31:0] last_req_addr;
   int          req_cyc_q[$];

   // A redirect target takes effect: new fetch address, maybe a fault.
   task automatic m_apply(input logic [31:0] t);
`ifdef YSYX_23060332_MISALIGN_CHK_EN
      m_fetch_addr = t;
      m_fault      = (t[1:0] != 2'b00);
`else
      m_fetch_addr = {t[31:2], 2'b00};
`endif
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = RESET_PC | 32'($urandom_range(4095));
`ifdef YSYX_23060332_MISALIGN_CHK_EN
      t[1:0] = 2'b00;
`endif
      return t;
   endfunction

   // One clock cycle. Entered at posedge+1, when the DUT outputs for this
   // cycle are settled. Drives the inputs, updates the model for the
   // handshakes that will happen at the coming edge, then advances.
   task automatic step();
      bit req_hs, rsp_hs, inst_hs, jmp;
      bus.imem_req_ready = ($urandom_range(99) < req_rdy_pct);
      bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
      bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(mem_addr) : $urandom;
      bus.inst_ready     = ($urandom_range(99) < inst_rdy_pct);
      jmp = force_jump || (since_rst > 0 && jump_pct > 0 && $urandom_range(99) < jump_pct);
      jump_en   = jmp;
      jump_addr = force_jump ? force_addr : rand_target();
      force_jump = 1'b0;

      req_hs  = bus.imem_req_valid && bus.imem_req_ready;
      rsp_hs  = bus.imem_rsp_valid && bus.imem_rsp_ready;
      inst_hs = bus.inst_valid && bus.inst_ready;

      if (m_fault) begin
         if (jmp) m_apply(jump_addr);
      end else if (m_held) begin
         if (jmp) begin
            if (!inst_hs) void'(exp_inst_q.pop_back());   // offer withdrawn
            m_held = 1'b0;
            m_apply(jump_addr);
         end else if (inst_hs) begin
            m_held = 1'b0;
            m_fetch_addr = m_fetch_addr + 32'd4;
         end
      end else begin
         if (req_hs) exp_req_q.push_back(m_fetch_addr);
         if (rsp_hs) begin
            if (jmp) begin
               m_pend = 1'b0;
               m_apply(jump_addr);
            end else if (m_pend) begin
               m_pend = 1'b0;
               m_apply(m_pend_addr);
            end else begin
               exp_inst_q.push_back('{pc: m_fetch_addr, word: mem_word(m_fetch_addr)});
               m_held = 1'b1;
            end
         end else if (jmp) begin
            m_pend      = 1'b1;
            m_pend_addr = jump_addr;
         end
      end

      if (req_hs) begin
         mem_busy = 1'b1;
         mem_addr = bus.imem_req_addr;
         mem_cnt  = int'($urandom_range(lat_hi - 1, lat_lo - 1));
         req_cyc_q.push_back(cyc);
      end else if (rsp_hs) begin
         mem_busy = 1'b0;
      end else if (mem_busy && mem_cnt > 0) begin
         mem_cnt--;
      end
      last_req_hs   = req_hs;
      last_req_addr = bus.imem_req_addr;
      if (inst_hs) n_delivered++;

      @(posedge clk);
      #1;
      cyc++;
      since_rst++;
   endtask

   // Reset for two cycles and check the reset state, then clear the models.
   task automatic do_reset();
      rst = 1'b1;
      jump_en = 1'b0;
      jump_addr = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.inst_ready     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",         pc,                 RESET_PC);
      check("rst_inst_valid", bus.inst_valid,     1'b0);
      check("rst_inst",       bus.inst,           32'h0);
      check("rst_inst_pc",    bus.inst_pc,        32'h0);
      check("rst_req_valid",  bus.imem_req_valid, 1'b0);
      check("rst_rsp_ready",  bus.imem_rsp_ready, 1'b0);
      check("rst_fault",      fetch_fault,        1'b0);
      exp_req_q.delete();
      exp_inst_q.delete();
      req_cyc_q.delete();
      mem_busy = 1'b0;
      m_fetch_addr = RESET_PC;
      m_pend  = 1'b0;
      m_held  = 1'b0;
      m_fault = 1'b0;
      force_jump = 1'b0;
      rst = 1'b0;
      since_rst = 0;
   endtask

   task automatic set_knobs(input int rr, input int lo, input int hi, input int ir, input int jp);
      req_rdy_pct  = rr;
      lat_lo       = lo;
      lat_hi       = hi;
      inst_rdy_pct = ir;
      jump_pct     = jp;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
            if (exp_req_q.size() != 0) check("req_addr", bus.imem_req_addr, exp_req_q.pop_front());
         end
         if (bus.inst_valid && bus.inst_ready) begin
            check("inst_expected", 32'(exp_inst_q.size() != 0), 32'd1);
            if (exp_inst_q.size() != 0) begin
               inst_t e;
               e = exp_inst_q.pop_front();
               check("inst_pc", bus.inst_pc, e.pc);
               check("inst",    bus.inst,    e.word);
            end
         end
      end
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      bit          saw_iv;
      int          n_hs;
      int          start_deliv;
      logic [31:0] exp_pc;
      cyc = 0;
      n_delivered = 0;
      set_knobs(100, 1, 1, 100, 0);
      do_reset();

      // First request appears in the second cycle after reset deasserts.
      check("idle_no_req", bus.imem_req_valid, 1'b0);
      step();
      check("first_req_valid", bus.imem_req_valid, 1'b1);
      check("first_req_addr",  bus.imem_req_addr,  RESET_PC);

      // Zero-wait memory, IDU always ready: one request every 3 cycles.
      for (int i = 0; i < 12; i++) step();
      check("zw_req_count", 32'(req_cyc_q.size() >= 3), 32'd1);
      if (req_cyc_q.size() >= 3) begin
         check("zw_gap0", 32'(req_cyc_q[1] - req_cyc_q[0]), 32'd3);
         check("zw_gap1", 32'(req_cyc_q[2] - req_cyc_q[1]), 32'd3);
      end

      // 5-cycle memory, IDU stalls 4 cycles: instruction held, no new request.
      set_knobs(100, 5, 5, 0, 0);
      for (int i = 0; i < 40 && !bus.inst_valid; i++) step();
      check("stall_inst_valid", bus.inst_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_req_valid", bus.imem_req_valid, 1'b0);
         check("stall_pc", pc, m_fetch_addr);
         check("stall_q", 32'(exp_inst_q.size()), 32'd1);
         if (exp_inst_q.size() != 0) begin
            check("stall_inst",    bus.inst,    exp_inst_q[0].word);
            check("stall_inst_pc", bus.inst_pc, exp_inst_q[0].pc);
         end
      end
      exp_pc = m_fetch_addr + 32'd4;
      inst_rdy_pct = 100;
      step();
      check("stall_pc_adv",   pc,                 exp_pc);
      check("b2b_req_valid",  bus.imem_req_valid, 1'b1);

      // Redirect during WAIT: stale response dropped, target fetched next.
      for (int i = 0; i < 20 && !bus.imem_rsp_ready; i++) step();
      check("wait_reached", bus.imem_rsp_ready, 1'b1);
      force_jump = 1'b1;
      force_addr = 32'h8000_0100;
      saw_iv = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_req_hs) break;
         saw_iv |= bus.inst_valid;
      end
      check("wj_no_inst",  saw_iv,        1'b0);
      check("wj_req_seen", last_req_hs,   1'b1);
      check("wj_req_addr", last_req_addr, 32'h8000_0100);

      // Two redirects in REQ while memory refuses: address stable, last wins.
      set_knobs(0, 2, 2, 100, 0);
      for (int i = 0; i < 20 && !bus.imem_req_valid; i++) step();
      check("rq_req_valid", bus.imem_req_valid, 1'b1);
      exp_pc = m_fetch_addr;
      force_jump = 1'b1;
      force_addr = 32'h8000_0200;
      step();
      check("rq_addr_stable0", bus.imem_req_addr, exp_pc);
      force_jump = 1'b1;
      force_addr = 32'h8000_0300;
      step();
      step();
      check("rq_addr_stable1", bus.imem_req_addr,  exp_pc);
      check("rq_still_valid",  bus.imem_req_valid, 1'b1);
      req_rdy_pct = 100;
      n_hs = 0;
      saw_iv = 1'b0;
      for (int i = 0; i < 30 && n_hs < 2; i++) begin
         step();
         if (last_req_hs) n_hs++;
         if (n_hs < 2) saw_iv |= bus.inst_valid;
      end
      check("rq_hs_count", 32'(n_hs),      32'd2);
      check("rq_no_inst",  saw_iv,         1'b0);
      check("rq_target",   last_req_addr,  32'h8000_0300);

      // Redirect and inst_ready in the same HOLD cycle: redirect wins.
      set_knobs(100, 1, 2, 0, 0);
      for (int i = 0; i < 20 && !bus.inst_valid; i++) step();
      check("hj_inst_valid", bus.inst_valid, 1'b1);
      inst_rdy_pct = 100;
      force_jump = 1'b1;
      force_addr = 32'h8000_0400;
      step();
      check("hj_req_valid",  bus.imem_req_valid, 1'b1);
      check("hj_req_addr",   bus.imem_req_addr,  32'h8000_0400);
      check("hj_inst_clear", bus.inst_valid,     1'b0);

      // Misaligned redirect target.
      inst_rdy_pct = 0;
      for (int i = 0; i < 20 && !bus.inst_valid; i++) step();
      check("ma_inst_valid", bus.inst_valid, 1'b1);
      force_jump = 1'b1;
      force_addr = 32'h8000_0102;
      step();
`ifdef YSYX_23060332_MISALIGN_CHK_EN
      check("ma_fault", fetch_fault, 1'b1);
      check("ma_pc",    pc,          32'h8000_0102);
      for (int i = 0; i < 5; i++) begin
         step();
         check("ma_no_req",  bus.imem_req_valid, 1'b0);
         check("ma_no_inst", bus.inst_valid,     1'b0);
      end
      force_jump = 1'b1;
      force_addr = 32'h8000_0000;
      step();
      check("ma_fault_clr", fetch_fault,        1'b0);
      check("ma_req_valid", bus.imem_req_valid, 1'b1);
      check("ma_req_addr",  bus.imem_req_addr,  32'h8000_0000);
`else
      check("ma_fault_tied", fetch_fault,        1'b0);
      check("ma_pc_aligned", pc,                 32'h8000_0100);
      check("ma_req_addr",   bus.imem_req_addr,  32'h8000_0100);
`endif

      // PC wrap from FFFF_FFFC to 0.
      set_knobs(100, 1, 1, 100, 0);
      step();
      force_jump = 1'b1;
      force_addr = 32'hFFFF_FFF8;
      n_hs = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_req_hs && last_req_addr == 32'h0) n_hs++;
      end
      check("wrap_zero_fetched", 32'(n_hs), 32'd1);

      // Randomized traffic with random redirects.
      set_knobs(60, 1, 4, 50, 4);
      start_deliv = n_delivered;
      for (int i = 0; i < 3000; i++) step();
      check("rand_progress", 32'(n_delivered - start_deliv >= 100), 32'd1);

      // Reset in the middle of a fetch, then restart from RESET_PC.
      set_knobs(100, 5, 5, 100, 0);
      for (int i = 0; i < 40 && !bus.imem_rsp_ready; i++) step();
      check("mid_wait_reached", bus.imem_rsp_ready, 1'b1);
      do_reset();
      step();
      check("mid_req_addr", bus.imem_req_addr, RESET_PC);
      lat_lo = 1;
      lat_hi = 1;
      for (int i = 0; i < 12; i++) step();

      // Drain and confirm every expectation was consumed.
      jump_pct = 0;
      for (int i = 0; i < 10; i++) step();
      check("req_q_drained",  32'(exp_req_q.size()),  32'd0);
      check("inst_q_drained", 32'(exp_inst_q.size()), 32'(m_held));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ysyx_23060332_fetch_ctrl.md
# ysyx_23060332_fetch_ctrl

Instruction-fetch controller for the single-issue core. It owns the fetch PC and sequences fetches: it issues a request to instruction memory over a valid/ready handshake, waits for the response, and presents the instruction to the IDU over a second handshake. It applies EXU redirects (jump/branch) at a defined point and discards any fetch made stale by a redirect. It replaces the free-running PC register, which advanced every cycle regardless of memory latency.

## Interface
- `RESET_PC`, default `32'h8000_0000`: fetch address after reset.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `jump_en`, in, 1: one-cycle redirect pulse from the EXU.
- `jump_addr`, in, 32: redirect target, sampled when `jump_en` is 1.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request.
- `imem_req_addr`, out, 32: fetch address; equals `pc`.
- `imem_rsp_valid`, in, 1: response valid.
- `imem_rsp_data`, in, 32: fetched instruction word.
- `imem_rsp_ready`, out, 1: 1 exactly in state WAIT.
- `inst_valid`, out, 1: instruction valid to the IDU.
- `inst_ready`, in, 1: IDU accepts the instruction.
- `inst`, out, 32: instruction to the IDU (registered).
- `inst_pc`, out, 32: PC of `inst` (registered).
- `pc`, out, 32: current fetch PC.
- `fetch_fault`, out, 1: misaligned redirect target (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- Reset: state=IDLE; `pc`=`RESET_PC`; `inst`=0; `inst_pc`=0; `inst_valid`=0; redirect-pending flag `rp`=0; drop flag `drop`=0; `fetch_fault`=0. `imem_req_valid` and `imem_rsp_ready` are 0.
- IDLE: moves to REQ unconditionally on the next edge.
- REQ: `imem_req_valid`=1. `imem_req_addr` stays stable until the request is accepted. On `imem_req_ready`, moves to WAIT.
- WAIT: `imem_rsp_ready`=1. On `imem_rsp_valid`:
  - If `drop`=0 and `rp`=0: latch `inst`=`imem_rsp_data` and `inst_pc`=`pc`; set `inst_valid`=1; move to HOLD.
  - Otherwise: discard the response; set `pc`=`rp_addr`; clear `rp` and `drop`; move to REQ.
- HOLD: `inst_valid`=1. On `inst_ready`: clear `inst_valid`; set `pc`=`pc`+4 (mod 2^32, wraps from `32'hFFFF_FFFC` to 0); move to REQ.
- Redirect (`jump_en`=1):
  - IDLE or HOLD: `pc`=`jump_addr`; `inst_valid` is cleared next cycle; move to REQ. This also applies when `inst_ready` is 1 in the same cycle: the redirect wins and the IDU handshake still completes.
  - REQ or WAIT: set `rp`=1 and `rp_addr`=`jump_addr`. The in-flight or about-to-issue fetch is completed on the bus and then discarded in WAIT.
  - Repeated redirects while `rp`=1: the latest `jump_addr` wins.
- Bus transactions are never abandoned. A request once asserted stays asserted until accepted, and an accepted request always consumes exactly one response.

## Timing
- Fetch latency: request accepted at edge t, response at edge t+k (k≥1). `inst_valid` rises in the cycle after the response handshake.
- Back-to-back: `inst` handshake at edge n gives `imem_req_valid`=1 in cycle n+1. Minimum is 3 cycles per instruction with a zero-wait memory.
- After reset: first `imem_req_valid` is in the second cycle after `rst` deasserts.
- Redirect in HOLD at edge n: `imem_req_addr`=`jump_addr` in cycle n+1.
- Redirect in REQ/WAIT: the target is fetched in the cycle after the stale response is consumed.
- `rst` asserted mid-transaction: returns to the reset state at the next edge. Any outstanding response is not tracked; the memory side is reset together with the controller.
- `inst`, `inst_pc`, `inst_valid` and `pc` are registers. `imem_*_valid/ready` are decoded from state only.

## Configuration
- `YSYX_23060332_MISALIGN_CHK_EN` defined:
  - A redirect applied with `jump_addr[1:0]`≠0 sets `pc`=`jump_addr`, sets `fetch_fault`=1, and enters FAULT.
  - FAULT issues no requests and holds `inst_valid`=0.
  - FAULT exits only on an aligned redirect (to REQ, clearing `fetch_fault`) or on reset.
  - For REQ/WAIT redirects, the check is made when `rp_addr` is applied.
- Macro undefined: `pc[1:0]` is forced to 0 on redirect, `fetch_fault` is tied 0, and FAULT is unreachable.

## Test plan
- Reset, zero-wait memory, `inst_ready`=1: request addresses are 0x80000000, 0x80000004, 0x80000008, one every 3 cycles, with matching `inst_pc`.
- Memory with 5-cycle response and `inst_ready` held low for 4 cycles: `inst` and `inst_pc` are stable, no new request is issued, and `pc` advances by 4 only after the handshake.
- `jump_en` with target 0x80000100 during WAIT: the stale response is dropped with no `inst_valid`; the next request address is 0x80000100.
- Two `jump_en` pulses (0x80000200, then 0x80000300) during REQ with `imem_req_ready`=0: the request address is stable until accepted, then the response is dropped and 0x80000300 is fetched.
- `jump_en` and `inst_ready` in the same HOLD cycle: the next request address equals `jump_addr`, not `inst_pc`+4.
- With the macro, `jump_addr`=0x80000102: `fetch_fault`=1 and no requests follow. A subsequent redirect to 0x80000000 clears the fault and fetches 0x80000000.
